// File: rtl/fdtd_pkg.sv
// Shared types and default latencies for the 1-D FDTD update schedulers.
// Used by the Ez sequencer, the Hy sequencer and their token pipes.
package fdtd_pkg;

    localparam int FDTD_ADDR_W     = 10;
    localparam int FDTD_MEM_RD_LAT = 1;
    localparam int FDTD_PIPE_LAT   = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_WAIT_HY
    } ez_sched_state_t;

    typedef struct packed {
        logic                   valid;
        logic                   wb;
        logic [FDTD_ADDR_W-1:0] addr;
    } ez_tok_t;

endpackage

// File: rtl/fdtd_tok_pipe.sv
// Enable-gated shift register of scheduler tokens that tracks operands through
// the memory + calc latency. Only the valid bits are reset.
module fdtd_tok_pipe
    import fdtd_pkg::*;
#(
    parameter int DEPTH = FDTD_MEM_RD_LAT + FDTD_PIPE_LAT
) (
    input  logic    CLK,
    input  logic    RST_N,
    input  logic    en,
    input  ez_tok_t tok_in,
    output ez_tok_t tok_out,
    output logic    empty
);

    logic [DEPTH-1:0]       vld_p;
    logic [DEPTH-1:0]       wb_p;
    logic [FDTD_ADDR_W-1:0] addr_p [DEPTH];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vld_p <= '0;
        end else if (en) begin
            vld_p[0] <= tok_in.valid;
            for (int i = 1; i < DEPTH; i++) vld_p[i] <= vld_p[i-1];
        end
    end

    // Payload is qualified by vld_p, so it carries no reset.
    always_ff @(posedge CLK) begin
        if (en) begin
            wb_p[0]   <= tok_in.wb;
            addr_p[0] <= tok_in.addr;
            for (int i = 1; i < DEPTH; i++) begin
                wb_p[i]   <= wb_p[i-1];
                addr_p[i] <= addr_p[i-1];
            end
        end
    end

    assign tok_out = '{valid: vld_p[DEPTH-1], wb: wb_p[DEPTH-1], addr: addr_p[DEPTH-1]};
    assign empty   = ~|vld_p;

endmodule

// File: rtl/fdtd_ez_sched.sv
// Ez update sequencer: streams cell reads into the Ez datapath, tracks them through
// the pipeline latency, issues write-backs for cells 1..nx-1 and steps with the Hy updater.
module fdtd_ez_sched
    import fdtd_pkg::*;
#(
    parameter int FDTD_DATA_WIDTH = 32,
    parameter int ADDR_WIDTH      = 10,
    parameter int STEP_WIDTH      = 16,
    parameter int MEM_RD_LAT      = FDTD_MEM_RD_LAT,
    parameter int PIPE_LAT        = FDTD_PIPE_LAT
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] nx_i,
    input  logic [STEP_WIDTH-1:0] nsteps_i,
    input  logic                  hold_i,
    input  logic                  hy_done_i,
    output logic                  rd_en_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    output logic                  clken_o,
    output logic                  wr_en_o,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic                  step_done_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam int TOK_DEPTH = MEM_RD_LAT + PIPE_LAT;

    if (ADDR_WIDTH > FDTD_ADDR_W || FDTD_DATA_WIDTH < 1 || TOK_DEPTH < 1) begin : g_bad_param
        $error("fdtd_ez_sched: unsupported parameter combination");
    end

    ez_sched_state_t       state_q, state_d;
    logic [ADDR_WIDTH-1:0] nx_q, nx_d, rd_cnt_q, rd_cnt_d;
    logic [STEP_WIDTH-1:0] nsteps_q, nsteps_d, step_cnt_q, step_cnt_d;
    logic                  err_q, err_d, hy_pend_q, hy_pend_d;
    logic                  busy, clken, rd_en, step_done, done, last_step, pipe_empty;
    ez_tok_t               tok_in, tok_out;

    assign busy      = (state_q != ST_IDLE);
    assign clken     = busy & ~hold_i;
    assign last_step = (step_cnt_q == nsteps_q - STEP_WIDTH'(1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            nx_q       <= '0;
            nsteps_q   <= '0;
            rd_cnt_q   <= '0;
            step_cnt_q <= '0;
            err_q      <= 1'b0;
            hy_pend_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            nx_q       <= nx_d;
            nsteps_q   <= nsteps_d;
            rd_cnt_q   <= rd_cnt_d;
            step_cnt_q <= step_cnt_d;
            err_q      <= err_d;
            hy_pend_q  <= hy_pend_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        nx_d       = nx_q;
        nsteps_d   = nsteps_q;
        rd_cnt_d   = rd_cnt_q;
        step_cnt_d = step_cnt_q;
        err_d      = err_q;
        hy_pend_d  = hy_pend_q;
        rd_en      = 1'b0;
        step_done  = 1'b0;
        done       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (nx_i >= ADDR_WIDTH'(2) && nsteps_i != '0) begin
                        nx_d       = nx_i;
                        nsteps_d   = nsteps_i;
                        rd_cnt_d   = '0;
                        step_cnt_d = '0;
                        err_d      = 1'b0;
                        state_d    = ST_RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (clken) begin
                    rd_en = 1'b1;
                    if (rd_cnt_q == nx_q - ADDR_WIDTH'(1)) state_d  = ST_DRAIN;
                    else                                    rd_cnt_d = rd_cnt_q + ADDR_WIDTH'(1);
                end
            end
            ST_DRAIN: begin
                // Wait for the final write-back to leave the pipe before ending the step.
                if (clken && pipe_empty) begin
                    if (last_step) begin
                        done    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        step_done = 1'b1;
                        state_d   = ST_WAIT_HY;
                    end
                end
            end
            ST_WAIT_HY: begin
                // A hy_done pulse arriving during hold is remembered until hold drops.
                if (hy_done_i) hy_pend_d = 1'b1;
                if (clken && (hy_done_i || hy_pend_q)) begin
                    hy_pend_d  = 1'b0;
                    step_cnt_d = step_cnt_q + STEP_WIDTH'(1);
                    rd_cnt_d   = '0;
                    state_d    = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Cell 0 only primes the datapath's Hy delay, so it never writes back.
    assign tok_in = '{valid: rd_en, wb: (rd_cnt_q != '0), addr: FDTD_ADDR_W'(rd_cnt_q)};

    fdtd_tok_pipe #(
        .DEPTH (TOK_DEPTH)
    ) u_tok_pipe (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .en      (clken),
        .tok_in  (tok_in),
        .tok_out (tok_out),
        .empty   (pipe_empty)
    );

    assign rd_en_o     = rd_en;
    assign rd_addr_o   = rd_cnt_q;
    assign clken_o     = clken;
    assign wr_en_o     = tok_out.valid & tok_out.wb & clken;
    assign wr_addr_o   = wr_en_o ? ADDR_WIDTH'(tok_out.addr) : '0;
    assign step_done_o = step_done;
    assign busy_o      = busy;
    assign done_o      = done;
    assign err_o       = err_q;

endmodule

// File: doc/fdtd_ez_sched.md
# fdtd_ez_sched

Sequencer for the 1-D FDTD Ez update pipeline. On each time step it streams field-memory reads for cells 0..nx-1 into the Ez calc datapath. It drives the datapath clock enable and tracks tokens through the pipeline latency. It issues Ez write-backs for cells 1..nx-1, then hands off to the Hy updater and repeats for the programmed number of steps.

## Interface
- `FDTD_DATA_WIDTH`, 32: datapath word width; this block only forwards the value.
- `ADDR_WIDTH`, 10: cell address width.
- `STEP_WIDTH`, 16: time-step counter width.
- `MEM_RD_LAT`, 1: field-memory read latency, in cycles.
- `PIPE_LAT`, 4: Ez calc latency, in clken-qualified cycles, from Hy/Ez operands in to Ez_n out.
- `CLK`  in  1: clock.
- `RST_N`  in  1: asynchronous active-low reset.
- `start_i`  in  1: one-cycle start pulse; ignored unless in IDLE.
- `nx_i`  in  ADDR_WIDTH: cell count; latched on start.
- `nsteps_i`  in  STEP_WIDTH: time-step count; latched on start.
- `hold_i`  in  1: freeze request (memory arbitration loss or host pause).
- `hy_done_i`  in  1: Hy updater finished the current step (pulse or level).
- `rd_en_o`  out  1: field-memory read enable for Hy/Ez at `rd_addr_o`.
- `rd_addr_o`  out  ADDR_WIDTH: read cell index.
- `clken_o`  out  1: datapath clock enable.
- `wr_en_o`  out  1: Ez write-back enable.
- `wr_addr_o`  out  ADDR_WIDTH: write-back cell index.
- `step_done_o`  out  1: one-cycle pulse after the last Ez write of a step.
- `busy_o`  out  1: high in any state other than IDLE.
- `done_o`  out  1: one-cycle pulse when all steps are complete.
- `err_o`  out  1: sticky flag, set when start occurs with nx_i<2 or nsteps_i==0; cleared by the next valid start.

## Operation
- FSM states: IDLE, RUN, DRAIN, WAIT_HY.
- **IDLE**
  - On start_i with nx≥2 and nsteps≥1: latch both values, set rd counter=0 and step counter=0, go to RUN.
  - On start_i with an invalid nx or nsteps: set err_o and stay in IDLE.
- **RUN**
  - Each cycle with !hold_i: rd_en_o=1, rd_addr_o=counter, counter++.
  - After issuing address nx-1, go to DRAIN.
- **DRAIN**
  - No reads are issued.
  - Leave when the token pipe is empty.
  - If the step counter is now nsteps-1: pulse done_o and go to IDLE.
  - Otherwise: pulse step_done_o and go to WAIT_HY.
- **WAIT_HY**
  - On hy_done_i: step counter++, rd counter=0, go to RUN.
  - hy_done_i is ignored in every other state.
- **Token pipe**
  - It is MEM_RD_LAT+PIPE_LAT deep. Each stage holds {valid, wb, addr}.
  - A token is injected with each read. wb=0 for addr 0, because the first Hy only primes the datapath's Hy delay; wb=1 otherwise.
  - The pipe shifts only when clken_o=1.
  - wr_en_o = exit_valid & exit_wb & clken_o; wr_addr_o = exit_addr.
- **Clock enable:** clken_o = !hold_i while busy. Every pipeline stage and every counter advances only on clken_o.
- **Write count:** exactly nx-1 writes per step, addresses 1..nx-1 in ascending order.

## Timing
- **Reset values:** FSM in IDLE; all outputs 0; rd_addr_o and wr_addr_o are 0.
- **Start latency:** start_i sampled in cycle t gives the first rd_en_o in cycle t+1.
- **Throughput:** one read per cycle with no hold, so a step's reads take nx cycles.
- **Write latency:** the write for the read issued at cycle r appears at r + MEM_RD_LAT + PIPE_LAT, plus any hold cycles.
- **Step time:** with no holds, step_done_o fires at t+1+nx+MEM_RD_LAT+PIPE_LAT.
- **Hold**
  - While hold_i=1, rd_en_o, wr_en_o and clken_o are all 0 and all state freezes.
  - Hold is also honoured in WAIT_HY.
- **Simultaneous events**
  - start_i while busy: ignored.
  - hold_i together with hy_done_i in WAIT_HY: the transition is deferred until hold drops. hy_done_i must be held, or it is captured into a sticky bit that clears on the transition.
- **Reset mid-step:** abort immediately. Pipe is flushed, no write-back and no done pulse.
- **Wrap-around:** the rd counter never exceeds nx-1. The step counter compares against nsteps-1, so nsteps = 2^STEP_WIDTH-1 runs fully.

## Structure
- Package `fdtd_pkg`:
  - FSM state enum `ez_sched_state_t`.
  - Token struct `ez_tok_t` {valid, wb, addr}.
  - Default latency constants shared with the calc and Hy blocks.
- One sub-module: `fdtd_tok_pipe`, a parameterised-depth shift register of `ez_tok_t` with an enable. It is reusable by the Hy scheduler.

## Test plan
- **Basic run:** nx=8, nsteps=1, no hold → reads at addresses 0..7 on consecutive cycles; 7 writes at 1..7 starting 1+MEM_RD_LAT+PIPE_LAT cycles after the first read; done_o once; step_done_o never.
- **Multi-step:** nx=4, nsteps=3, hy_done_i pulsed 5 cycles after each step_done_o → 2 step_done_o pulses, 9 total writes, done_o after the third drain.
- **Hold:** hold_i high for 3 cycles mid-RUN (nx=16) → no rd/wr/clken during the hold; same address sequence; completion delayed by exactly 3 cycles.
- **Invalid start:** start with nx=1 → err_o=1, busy_o stays 0. A following start with nx=5, nsteps=1 clears err_o and completes normally.
- **Reset:** RST_N low in the middle of DRAIN → all outputs 0 asynchronously. After release no stale write-back occurs, and a new start runs cleanly.
- **Spurious inputs:** start_i asserted in RUN and hy_done_i asserted in RUN → no effect on sequence or counts.
